sevseg_scan_ctrl: RTL and testbench
===================================

SEVSEG_SCAN_CTRL -- requirements
Module: sevseg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles each digit is lit (>= GUARD+2).
REQ-002 SHALL have parameter GUARD, default 16, cycles all anodes are off after each digit change (anti-ghosting).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port we  input  1  bus write strobe, one write per cycle when high.
REQ-006 SHALL have port addr  input  2  word address: 0=DATA, 1=CTRL, 2=STATUS, 3=reserved.
REQ-007 SHALL have port wdata  input  32  bus write data.
REQ-008 SHALL have port rdata  output  32  bus read data, combinational from addr.
REQ-009 SHALL have port seg  output  7  segment drive, active-low, registered.
REQ-010 SHALL have port dp  output  1  decimal point, active-low, registered.
REQ-011 SHALL have port an  output  8  digit anodes, active-low, one-hot-low or all-high, registered.

Function
REQ-012 SHALL hold DATA[31:0]: digit k shows nibble DATA[4k+3:4k], digit 0 rightmost.
REQ-013 SHALL hold CTRL: bit0 EN, bits[15:8] BLANK mask (1=digit dark), bits[23:16] DP mask (1=point lit); other bits write-ignored, read 0.
REQ-014 SHALL make STATUS read {29'b0, digit index[2:0]}; STATUS and reserved writes ignored; reserved reads 0.
REQ-015 SHALL update DATA/CTRL on the clk edge where we=1; new value visible on seg/an/dp one cycle later.
REQ-016 SHALL run a divider counter 0..REFRESH_DIV-1 while EN=1; at REFRESH_DIV-1 it wraps to 0 and digit index advances, 7 wrapping to 0.
REQ-017 SHALL run FSM states OFF, GUARD, DRIVE: OFF while EN=0; OFF->GUARD when EN=1; GUARD->DRIVE when counter = GUARD-1; DRIVE->GUARD on counter wrap; any state->OFF when EN=0.
REQ-018 SHALL in OFF and GUARD drive an=8'hFF, seg=7'h7F, dp=1.
REQ-019 SHALL in DRIVE drive an with only bit[index] low, seg=encoding of current nibble, dp=~DP[index]; if BLANK[index]=1, an=8'hFF for that slot.
REQ-020 SHALL encode nibbles 0-F active-low as (seg[6:0]): 0001000, 0111110, 0010001, 0010100, 0100110, 1000100, 1000000, 0011110, 0000000, 0000110, 0000010, 1100000, 1001001, 0110000, 1000001, 1000011.
REQ-021 SHALL, when EN is cleared, zero counter and index on the next edge; re-enable restarts at digit 0 in GUARD.
REQ-022 SHALL use the DATA/CTRL value of the current cycle (writes mid-slot take effect immediately, no slot restart).
REQ-023 SHALL, on a CTRL write clearing EN while in DRIVE, reach an=8'hFF on the following edge.

Reset
REQ-024 SHALL on reset force DATA=0, CTRL=0, counter=0, index=0, state OFF, an=8'hFF, seg=7'h7F, dp=1 immediately (asynchronously).
REQ-025 SHALL, on reset asserted mid-scan, discard the in-progress slot and resume only after software sets EN.

Structure
REQ-026 SHALL place the 16-entry segment table, register address constants, CTRL field positions and FSM state enum in package sevseg_pkg.
REQ-027 SHALL instantiate one combinational sub-module hex_to_sevseg (4-bit nibble in, 7-bit active-low segments out) using the package table.
REQ-028 SHALL keep divider, index, FSM and bus registers in sevseg_scan_ctrl; REFRESH_DIV counter width = $clog2(REFRESH_DIV).

Verification (REFRESH_DIV=8, GUARD=2)
REQ-029 SHALL check reset: reset high mid-DRIVE -> an=FF, seg=7F, dp=1 same cycle; rdata addr0/addr1 = 0.
REQ-030 SHALL check scan: DATA=0x76543210, CTRL=0x1 -> digits 0..7 in order, each an low 6 cycles after 2 dark cycles, seg digit0=0001000, digit7=0011110, index wraps 7->0.
REQ-031 SHALL check masks: CTRL=0x00_05_81_01 (DP digits 0,2; BLANK digits 0,7) -> digits 0 and 7 dark, digit 2 dp=0, others dp=1.
REQ-032 SHALL check mid-slot write: during digit 3 DRIVE write DATA=0x0000F000 -> seg=1000011 next cycle, slot length unchanged.
REQ-033 SHALL check disable: clear EN during DRIVE -> an=FF next cycle, STATUS=0 after; set EN -> GUARD then digit 0.
REQ-034 SHALL check bus decode: write addr2/addr3 -> no state change; CTRL write 0xFFFFFFFF reads back 0x00FFFF01.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// CTRL field positions, scan FSM states and the nibble-to-segment table.
package sevseg_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLANK_LSB = 8;
  localparam int CTRL_DP_LSB    = 16;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // Active-low segment patterns seg[6:0], entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h43, 7'h41, 7'h30, 7'h49,   // F E D C
    7'h60, 7'h02, 7'h06, 7'h00,   // B A 9 8
    7'h1E, 7'h40, 7'h44, 7'h26,   // 7 6 5 4
    7'h14, 7'h11, 7'h3E, 7'h08    // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_sevseg.sv
// Combinational nibble to active-low segment decoder.
module hex_to_sevseg
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with a small
// register interface (DATA, CTRL, STATUS). Each digit slot is a guard
// interval with all anodes off followed by the lit interval.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST       = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD_LAST = CW'(GUARD - 1);

  logic [31:0]   data_q;
  logic          en_q;
  logic [7:0]    blank_q;
  logic [7:0]    dpm_q;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  scan_state_e   state_q, state_d;

  logic [3:0]    nibble;
  logic [6:0]    seg_enc;
  logic          drive;

  // Bus-writable registers; only the defined CTRL fields are stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      en_q    <= 1'b0;
      blank_q <= '0;
      dpm_q   <= '0;
    end else if (we) begin
      case (addr)
        ADDR_DATA: data_q <= wdata;
        ADDR_CTRL: begin
          en_q    <= wdata[CTRL_EN_BIT];
          blank_q <= wdata[CTRL_BLANK_LSB +: 8];
          dpm_q   <= wdata[CTRL_DP_LSB +: 8];
        end
        default: ;
      endcase
    end
  end

  // Combinational read mux.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:   rdata = data_q;
      ADDR_CTRL:   rdata = {8'h00, dpm_q, blank_q, 7'h00, en_q};
      ADDR_STATUS: rdata = {29'b0, idx_q};
      ADDR_RSVD:   rdata = '0;
      default:     rdata = '0;
    endcase
  end

  // Scan state, divider and digit index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; clearing EN collapses everything back to OFF/0/0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en_q) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_GUARD;
        ST_GUARD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_GUARD_LAST) state_d = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            state_d = ST_GUARD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign nibble = data_q[{idx_q, 2'b00} +: 4];

  hex_to_sevseg u_hex (
    .nibble (nibble),
    .seg    (seg_enc)
  );

  // Gating on en_q darkens the display the cycle after a disabling write,
  // before the FSM itself has reached OFF.
  assign drive = (state_q == ST_DRIVE) && en_q;

  // Registered pad drivers built from the current register contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= (drive && !blank_q[idx_q]) ? ~(8'h01 << idx_q) : 8'hFF;
      seg <= drive ? seg_enc : 7'h7F;
      dp  <= drive ? ~dpm_q[idx_q] : 1'b1;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Self-checking bench for sevseg_scan_ctrl with REFRESH_DIV=8, GUARD=2.
// The reference model tracks a position counter since scan start and
// derives digit/phase by division, independent of the RTL's FSM.
module tb_sevseg_scan_ctrl;

  localparam int RD = 8;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sevseg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(G)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  // ---------------- reference model ----------------
  logic [6:0] seg_ref [16] = '{7'h08, 7'h3E, 7'h11, 7'h14, 7'h26, 7'h44, 7'h40, 7'h1E,
                               7'h00, 7'h06, 7'h02, 7'h60, 7'h49, 7'h30, 7'h41, 7'h43};
  logic [31:0] m_data;
  logic [31:0] m_ctrl;
  int          m_pos;   // cycles since scan start, -1 when idle
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  always @(posedge clk or posedge reset) begin
    int d;
    if (reset) begin
      m_data  = '0;
      m_ctrl  = '0;
      m_pos   = -1;
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      if (m_ctrl[0] && m_pos >= 0 && (m_pos % RD) >= G) begin
        d       = (m_pos / RD) % 8;
        exp_an  = m_ctrl[8 + d] ? 8'hFF : ~(8'h01 << d);
        exp_seg = seg_ref[m_data[4*d +: 4]];
        exp_dp  = ~m_ctrl[16 + d];
      end else begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end
      m_pos = m_ctrl[0] ? m_pos + 1 : -1;
      if (we && addr == 2'd0) m_data = wdata;
      if (we && addr == 2'd1) m_ctrl = wdata;
    end
  end

  function automatic logic [31:0] exp_rdata();
    case (addr)
      2'd0:    return m_data;
      2'd1:    return m_ctrl & 32'h00FF_FF01;
      2'd2:    return (m_pos >= 0) ? 32'((m_pos / RD) % 8) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("an",    32'(an),  32'(exp_an));
    chk("seg",   32'(seg), 32'(exp_seg));
    chk("dp",    32'(dp),  32'(exp_dp));
    chk("rdata", rdata,    exp_rdata());
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    check_all();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    step();
  endtask

  task automatic wait_lit(input logic [7:0] target, input string tag);
    for (int i = 0; i < 200; i++) begin
      step();
      if (target == 8'hFF ? (an != 8'hFF) : (an == target)) break;
    end
    if (target == 8'hFF) chk(tag, 32'(an != 8'hFF), 32'd1);
    else                 chk(tag, 32'(an), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_an",  32'(an),  32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp",  32'(dp),  32'h1);
    chk("rst_data", rdata, 32'h0);
    addr = 2'd1; #1;
    chk("rst_ctrl", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // full scan through all digits and the 7->0 wrap
    wr(2'd0, 32'h7654_3210);
    wr(2'd1, 32'h1);
    addr = 2'd2;
    for (int c = 1; c <= 72; c++) begin
      step();
      if (c == 3)  chk("scan_guard", 32'(an), 32'hFF);
      if (c == 4) begin
        chk("scan_d0_an",  32'(an),  32'hFE);
        chk("scan_d0_seg", 32'(seg), 32'h08);
      end
      if (c == 60) begin
        chk("scan_d7_an",  32'(an),  32'h7F);
        chk("scan_d7_seg", 32'(seg), 32'h1E);
      end
      if (c == 63) chk("scan_idx7", rdata, 32'd7);
      if (c == 65) chk("scan_idxwrap", rdata, 32'd0);
      if (c == 68) chk("scan_wrap_an", 32'(an), 32'hFE);
    end

    // blank and decimal-point masks
    wr(2'd1, 32'h0);
    wr(2'd1, 32'h0005_8101);
    addr = 2'd2;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (c == 4)  chk("mask_d0_dark", 32'(an), 32'hFF);
      if (c == 12) chk("mask_d1_dp",   32'(dp), 32'h1);
      if (c == 20) begin
        chk("mask_d2_an", 32'(an), 32'hFB);
        chk("mask_d2_dp", 32'(dp), 32'h0);
      end
      if (c == 60) chk("mask_d7_dark", 32'(an), 32'hFF);
    end

    // mid-slot DATA write on digit 3
    wr(2'd1, 32'h1);
    wr(2'd0, 32'h7654_3210);
    wait_lit(8'hF7, "wait_d3");
    wr(2'd0, 32'h0000_F000);
    step();
    chk("midslot_seg", 32'(seg), 32'h43);
    chk("midslot_an",  32'(an),  32'hF7);
    repeat (12) step();

    // disable during DRIVE, then re-enable
    wait_lit(8'hFF, "wait_lit_dis");
    wr(2'd1, 32'h0);
    step();
    chk("dis_an", 32'(an), 32'hFF);
    addr = 2'd2;
    step();
    chk("dis_status", rdata, 32'd0);
    wr(2'd1, 32'h1);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 3) chk("reen_guard", 32'(an), 32'hFF);
    end
    chk("reen_d0", 32'(an), 32'hFE);

    // bus decode: STATUS/reserved writes are ignored
    wr(2'd0, 32'hA5A5_1234);
    wr(2'd2, $urandom);
    wr(2'd3, $urandom);
    addr = 2'd0; #1;
    chk("dec_data", rdata, 32'hA5A5_1234);
    addr = 2'd1; #1;
    chk("dec_ctrl", rdata, 32'h1);
    addr = 2'd3; #1;
    chk("dec_rsvd", rdata, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    chk("ctrl_mask", rdata, 32'h00FF_FF01);

    // randomized traffic against the model
    wr(2'd1, 32'h1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        we    = 1'b1;
        addr  = 2'($urandom_range(0, 3));
        wdata = $urandom;
        if (addr == 2'd1 && $urandom_range(0, 9) != 0) wdata[0] = 1'b1;
      end else begin
        addr = 2'($urandom_range(0, 3));
      end
      step();
    end

    // asynchronous reset mid-DRIVE
    wr(2'd1, 32'h1);
    wait_lit(8'hFF, "wait_lit_rst");
    #2 reset = 1'b1;
    #1;
    chk("arst_an",  32'(an),  32'hFF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp",  32'(dp),  32'h1);
    addr = 2'd0; #1;
    chk("arst_data", rdata, 32'h0);
    addr = 2'd1; #1;
    chk("arst_ctrl", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    addr  = 2'd2;
    repeat (20) step();
    chk("arst_stay_dark", 32'(an), 32'hFF);
    wr(2'd1, 32'h1);
    repeat (4) step();
    chk("arst_resume_an",  32'(an),  32'hFE);
    chk("arst_resume_seg", 32'(seg), 32'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
